sr_fifo_uart_tx: RTL and testbench
==================================

# sr_fifo_uart_tx

Serial drain for the CPU's outbound FIFO: while the FIFO is non-empty, pops one word at a time and transmits it on a UART line as DATA_WIDTH/8 bytes, least significant byte first. Each byte is framed 8N1: one start bit, 8 data bits LSB first, one stop bit. Sits on the read side of `sr_fifo`, opposite the CPU's FIFO push instruction, and turns pushed register values into an off-chip debug/console stream.

## Interface
- `DATA_WIDTH`, 32, FIFO word width; must be a non-zero multiple of 8.
- `CLK_DIV`, 868, `clk` cycles per UART bit; must be ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `fifoEmpty`  in  1  FIFO has no word available.
- `fifoData`  in  DATA_WIDTH  FIFO head word; first-word fall-through, valid whenever `fifoEmpty`=0.
- `fifoPop`  out  1  consumes the head word at this rising edge; combinational.
- `tx`  out  1  serial line, idle high; registered.
- `busy`  out  1  a word is in flight (state ≠ IDLE); registered.

## Operation
- States: IDLE, START, DATA, STOP. Counters:
  - `divCnt`, 0..CLK_DIV-1: cycle within the current bit.
  - `bitCnt`, 0..7: data bit index.
  - `byteCnt`, 0..DATA_WIDTH/8-1: byte index within the word.
- Shift register `shReg`, DATA_WIDTH bits, holds the word being sent.
- `bitEnd` = (`divCnt` == CLK_DIV-1). `lastStop` = STOP & `bitEnd` & (`byteCnt` == DATA_WIDTH/8-1).
- `fifoPop` = !`fifoEmpty` & (IDLE | `lastStop`). Whenever `fifoPop` is high:
  - `shReg` ← `fifoData`; `byteCnt`, `bitCnt`, `divCnt` ← 0; next state START.
- IDLE: `tx`=1. `fifoEmpty` is ignored in every state except IDLE and the `lastStop` cycle.
- START: `tx`=0 for CLK_DIV cycles; at `bitEnd` → DATA.
- DATA: `tx`=`shReg[0]`. At `bitEnd`: `shReg` shifts right by 1 and `bitCnt`++. At `bitEnd` with `bitCnt`==7 → STOP.
- STOP: `tx`=1 for CLK_DIV cycles. At `bitEnd`:
  - if not the last byte: `byteCnt`++, → START.
  - else if `fifoPop`: reload as above, → START. There is no idle gap between words.
  - else → IDLE.
- `divCnt` resets to 0 at every `bitEnd` and on every state entry.
- After 8 right shifts per byte, the next byte sits in `shReg[7:0]`. No separate byte mux.

## Timing
- Reset values: `tx`=1, `busy`=0, state IDLE, all counters 0, `shReg`=0. `fifoPop`=0 during reset regardless of `fifoEmpty`.
- Latency: if `fifoEmpty` is 0 in IDLE at edge N, then `fifoPop`=1 in the cycle before edge N. `tx` falls and `busy` rises right after edge N.
- Each bit is exactly CLK_DIV cycles. Each byte is 10·CLK_DIV cycles. Each word is (DATA_WIDTH/8)·10·CLK_DIV cycles.
- Back-to-back words: the start bit of word k+1 immediately follows the stop bit of word k.
- Exactly one pop per word. `fifoPop` is never high for two consecutive cycles.
- Reset mid-frame: `tx`=1 on the next cycle. The in-flight word is discarded, not re-popped. No partial stop bit is owed.
- `fifoEmpty` rising during a frame has no effect. `fifoData` changing during a frame has no effect, because the word is latched.

## Structure
- Shared header `sr_cpu.vh` gets the state encodings `SR_UTX_IDLE`, `SR_UTX_START`, `SR_UTX_DATA`, `SR_UTX_STOP` (2 bits).
- One sub-module, `sr_uart_tick`: CLK_DIV counter with `clear` input and `bitEnd` output, synchronous active-high `reset`. Reused later by the RX side.
- Parameter legality is checked at elaboration; an illegal value is a fatal error.

## Test plan
- Reset/idle: `reset`=1 for 3 cycles, `fifoEmpty`=1 → `tx`=1, `busy`=0, `fifoPop`=0 for 100 cycles.
- Single word, CLK_DIV=4: `fifoData`=0x000000A5, `fifoEmpty` low for 1 cycle, then high.
  - `fifoPop` is high for 1 cycle.
  - `tx` sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1, then three frames of 0,0×8,1.
  - `busy` is high for exactly 160 cycles.
- Back-to-back: push 0x11223344 and 0xDEADBEEF →
  - bytes on line: 44,33,22,11,EF,BE,AD,DE.
  - the second `fifoPop` coincides with the last stop-bit cycle of the first word; there is no idle cycle.
- Ignore during frame: toggle `fifoEmpty` and change `fifoData` mid-word → no extra pops, and the transmitted word is unchanged.
- Reset mid-frame: assert `reset` in DATA bit 3 of byte 1 → `tx`=1 and `busy`=0 the next cycle.
  - A word pending in the FIFO then starts a fresh frame from byte 0 after reset is released.
- Parameters: DATA_WIDTH=8, CLK_DIV=2 → 20-cycle frames. An elaboration with DATA_WIDTH=12 fails.

Source files
------------

// File: rtl/sr_fifo_uart_tx_pkg.sv
// Shared types and helpers for the FIFO-draining UART transmitter and its bit timer.
package sr_fifo_uart_tx_pkg;

  typedef enum logic [1:0] {
    SR_UTX_IDLE  = 2'd0,
    SR_UTX_START = 2'd1,
    SR_UTX_DATA  = 2'd2,
    SR_UTX_STOP  = 2'd3
  } utx_state_e;

  localparam int unsigned BITS_PER_BYTE = 8;

  // Counter width that still works for a range of one value.
  function automatic int unsigned cnt_width(input int unsigned range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/sr_uart_tick.sv
// UART bit timer: counts CLK_DIV clocks per bit and flags the last cycle of each bit.
module sr_uart_tick
  import sr_fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitEnd
);

  localparam int unsigned CNT_W = cnt_width(CLK_DIV);

  if (CLK_DIV < 2) begin : g_bad_div
    $fatal(1, "sr_uart_tick: CLK_DIV must be at least 2");
  end

  logic [CNT_W-1:0] div_cnt;

  assign bitEnd = (div_cnt == CNT_W'(CLK_DIV - 1));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear || bitEnd) div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/sr_fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO onto an 8N1 UART line, one word at a time,
// least significant byte first, with no idle gap between back-to-back words.
module sr_fifo_uart_tx
  import sr_fifo_uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CLK_DIV    = 868
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifoEmpty,
  input  logic [DATA_WIDTH-1:0] fifoData,
  output logic                  fifoPop,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BITS_PER_BYTE;
  localparam int unsigned BYTE_W    = cnt_width(NUM_BYTES);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);

  if (DATA_WIDTH == 0 || (DATA_WIDTH % BITS_PER_BYTE) != 0) begin : g_bad_width
    $fatal(1, "sr_fifo_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end

  utx_state_e            state, state_n;
  logic [DATA_WIDTH-1:0] sh_reg, sh_n;
  logic [2:0]            bit_cnt, bit_n;
  logic [BYTE_W-1:0]     byte_cnt, byte_n;
  logic                  bit_end, last_stop, tx_n;

  // The timer is held at zero while idle, so a popped word always starts a full-length start bit.
  sr_uart_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == SR_UTX_IDLE),
    .bitEnd (bit_end)
  );

  assign last_stop = (state == SR_UTX_STOP) && bit_end && (byte_cnt == LAST_BYTE);
  assign fifoPop   = !reset && !fifoEmpty && ((state == SR_UTX_IDLE) || last_stop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SR_UTX_IDLE;
      sh_reg   <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      sh_reg   <= sh_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      tx       <= tx_n;
      busy     <= (state_n != SR_UTX_IDLE);
    end
  end

  // NOTE: every combinational output is given a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    sh_n    = sh_reg;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    case (state)
      SR_UTX_START: if (bit_end) state_n = SR_UTX_DATA;
      SR_UTX_DATA: begin
        if (bit_end) begin
          sh_n  = sh_reg >> 1;
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = SR_UTX_STOP;
        end
      end
      SR_UTX_STOP: begin
        if (bit_end) begin
          if (byte_cnt != LAST_BYTE) begin
            byte_n  = byte_cnt + 1'b1;
            state_n = SR_UTX_START;
          end else begin
            state_n = SR_UTX_IDLE;
          end
        end
      end
      default: ;
    endcase
    // A pop from IDLE or from the final stop bit latches the new word and restarts framing.
    if (fifoPop) begin
      sh_n    = fifoData;
      bit_n   = '0;
      byte_n  = '0;
      state_n = SR_UTX_START;
    end
  end

  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      SR_UTX_START: tx_n = 1'b0;
      SR_UTX_DATA:  tx_n = sh_n[0];
      default:      tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sr_fifo_uart_tx.sv
// Self-checking bench for sr_fifo_uart_tx: cycle-level line model, UART byte decoder,
// table-driven words, randomized traffic and hand-written corner sequences.
module tb_sr_fifo_uart_tx;

  localparam int DW       = 32;
  localparam int DIV      = 4;
  localparam int NB       = DW / 8;
  localparam int WORD_CYC = NB * 10 * DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_pop, tx, busy;

  logic          s_empty = 1'b1;
  logic [7:0]    s_data = '0;
  logic          s_pop, s_tx, s_busy;

  always #5 clk = ~clk;

  sr_fifo_uart_tx #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .fifoEmpty(fifo_empty), .fifoData(fifo_data),
    .fifoPop(fifo_pop), .tx(tx), .busy(busy)
  );

  sr_fifo_uart_tx #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_small (
    .clk(clk), .reset(reset), .fifoEmpty(s_empty), .fifoData(s_data),
    .fifoPop(s_pop), .tx(s_tx), .busy(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending FIFO words and the expected line level for every future cycle.
  logic [DW-1:0] fifo_q[$];
  logic          line_q[$];
  logic [7:0]    rx_q[$];
  bit            mon_en = 0, pend_pop = 0, ovr = 0;
  logic          ovr_empty = 1'b1;
  logic [DW-1:0] ovr_data = '0;
  int            pop_cnt = 0, busy_cnt = 0, cyc = 0, last_pop_cyc = 0, pop_gap = 0;

  // FIFO driver: updates the head word just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (pend_pop) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pend_pop = 0;
    end
    if (ovr) begin
      fifo_empty = ovr_empty;
      fifo_data  = ovr_data;
    end else begin
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : DW'($urandom());
    end
  end

  // Line monitor: compares tx/busy/fifoPop every cycle against the model.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      int         rem;
      logic       exp_tx, exp_pop;
      logic [7:0] byte_v;
      logic [9:0] frame;
      rem     = line_q.size();
      exp_pop = !reset && !fifo_empty && (rem <= 1);
      exp_tx  = (rem > 0) ? line_q[0] : 1'b1;
      check("tx", tx, exp_tx);
      check("busy", busy, rem > 0);
      check("fifoPop", fifo_pop, exp_pop);
      if (fifo_pop) begin
        pop_cnt++;
        pop_gap      = cyc - last_pop_cyc;
        last_pop_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (rem > 0) void'(line_q.pop_front());
      if (reset) begin
        line_q.delete();
      end else if (exp_pop) begin
        for (int b = 0; b < NB; b++) begin
          byte_v = 8'(fifo_data >> (8 * b));
          frame  = {1'b1, byte_v, 1'b0};
          for (int k = 0; k < 10; k++)
            repeat (DIV) line_q.push_back(frame[k]);
        end
        pend_pop = 1;
      end
    end
  end

  // UART receiver: samples mid-bit and collects decoded bytes.
  initial begin
    bit         rx_act = 0;
    logic       prev_tx = 1'b1;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (reset) begin
          rx_act = 0;
        end else if (!rx_act) begin
          if (prev_tx === 1'b1 && tx === 1'b0) begin
            rx_act = 1;
            rx_cnt = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt == DIV / 2) check("rx_start_bit", tx, 1'b0);
          for (int k = 1; k <= 8; k++)
            if (rx_cnt == k * DIV + DIV / 2) rx_byte[k-1] = tx;
          if (rx_cnt == 9 * DIV + DIV / 2) begin
            check("rx_stop_bit", tx, 1'b1);
            rx_q.push_back(rx_byte);
            rx_act = 0;
          end
        end
        prev_tx = tx;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while ((fifo_q.size() != 0 || line_q.size() != 0 || pend_pop) && c < budget) begin
      tick(1);
      c++;
    end
    check({name, "_in_time"}, c < budget, 1'b1);
    tick(3);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    check({name, "_byte_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(name, (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] line_order;  // bytes in transmission order, first byte in bits 31:24
    int          busy_cyc;
    int          pops;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0]  exp_b[$];
    logic [31:0] w, w2;
    logic [9:0]  sframe;

    vecs[0] = '{32'h0000_00A5, 32'hA500_0000, 160, 1};
    vecs[1] = '{32'h1122_3344, 32'h4433_2211, 160, 1};
    vecs[2] = '{32'h8000_0001, 32'h0100_0080, 160, 1};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 160, 1};

    // Reset for 3 cycles, then a long idle stretch with an empty FIFO.
    reset = 1'b1;
    tick(1);
    mon_en = 1;
    tick(2);
    reset = 1'b0;
    busy_cnt = 0; pop_cnt = 0;
    tick(100);
    check("idle_pops", pop_cnt, 0);
    check("idle_busy_cycles", busy_cnt, 0);

    // Table-driven single words.
    foreach (vecs[v]) begin
      rx_q.delete(); busy_cnt = 0; pop_cnt = 0;
      fifo_q.push_back(vecs[v].word);
      wait_idle("table_word", 2000);
      exp_b.delete();
      for (int i = 0; i < NB; i++) exp_b.push_back(vecs[v].line_order[31 - 8 * i -: 8]);
      check_bytes("table_bytes", exp_b);
      check("table_busy_cycles", busy_cnt, vecs[v].busy_cyc);
      check("table_pops", pop_cnt, vecs[v].pops);
    end

    // Back-to-back words: second pop lands on the last stop-bit cycle.
    rx_q.delete(); busy_cnt = 0; pop_cnt = 0;
    fifo_q.push_back(32'h1122_3344);
    fifo_q.push_back(32'hDEAD_BEEF);
    wait_idle("b2b", 2000);
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    check_bytes("b2b_bytes", exp_b);
    check("b2b_pops", pop_cnt, 2);
    check("b2b_pop_spacing", pop_gap, WORD_CYC);
    check("b2b_busy_cycles", busy_cnt, 2 * WORD_CYC);

    // Randomized words with random gaps, some arriving while a word is in flight.
    rx_q.delete(); exp_b.delete(); pop_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      w = $urandom();
      fifo_q.push_back(w);
      for (int i = 0; i < NB; i++) exp_b.push_back(8'(w >> (8 * i)));
      tick($urandom_range(1, 200));
    end
    wait_idle("random", 4000);
    check_bytes("random_bytes", exp_b);
    check("random_pops", pop_cnt, 5);

    // FIFO inputs wiggling mid-frame must be ignored.
    rx_q.delete(); pop_cnt = 0;
    w = $urandom();
    fifo_q.push_back(w);
    tick(40);
    ovr = 1;
    for (int i = 0; i < 60; i++) begin
      ovr_empty = 1'($urandom_range(0, 1));
      ovr_data  = $urandom();
      tick(1);
    end
    ovr = 0;
    wait_idle("ignore", 2000);
    exp_b.delete();
    for (int i = 0; i < NB; i++) exp_b.push_back(8'(w >> (8 * i)));
    check_bytes("ignore_bytes", exp_b);
    check("ignore_pops", pop_cnt, 1);

    // Reset during data bit 3 of byte 1; the pending second word then starts cleanly.
    w  = 32'hC3A5_5A3C;
    w2 = 32'h0F1E_2D4B;
    fifo_q.push_back(w);
    fifo_q.push_back(w2);
    for (int c = 0; c < 300 && !(line_q.size() > 0 && line_q.size() <= WORD_CYC - 57); c++)
      tick(1);
    check("rst_reached_bit3", line_q.size(), WORD_CYC - 57);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rx_q.delete(); pop_cnt = 0;
    @(negedge clk);
    check("rst_tx_high", tx, 1'b1);
    check("rst_busy_low", busy, 1'b0);
    tick(1);
    wait_idle("after_reset", 2000);
    exp_b.delete();
    for (int i = 0; i < NB; i++) exp_b.push_back(8'(w2 >> (8 * i)));
    check_bytes("after_reset_bytes", exp_b);
    check("after_reset_pops", pop_cnt, 1);

    // 8-bit word with 2-cycle bits: one 20-cycle frame.
    s_data  = 8'h5A;
    s_empty = 1'b0;
    @(negedge clk);
    check("small_pop", s_pop, 1'b1);
    @(posedge clk);
    #2;
    s_empty = 1'b1;
    sframe = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("small_tx", s_tx, (i < 20) ? sframe[i / 2] : 1'b1);
      check("small_busy", s_busy, i < 20);
      check("small_no_pop", s_pop, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
